clock_divider_bank: RTL and testbench

- Parametrised bank of N_CH independent clock dividers, each with a run-time divisor.
- Each channel produces a 50 %-duty square-wave enable signal and a one-cycle tick on its rising edge.
- Supersedes the fixed two-divider block: the 1 Hz and blink rates become programmable channels.
- Divisor changes are glitch-free, and a common sync input phase-aligns all channels.

---
 rtl/clock_divider_bank.sv | 67 ++++++
 tb/tb_clock_divider_bank.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// Bank of N_CH programmable 50%-duty clock dividers with glitch-free divisor update and common sync.
// Optional CLOCK_DIVIDER_BANK_PAUSE_EN adds a pause input that freezes all channels without phase loss.
module clock_divider_bank #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*CNT_W-1:0] div_in,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync,
`ifdef CLOCK_DIVIDER_BANK_PAUSE_EN
  input  logic                  pause,
`endif
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       busy
);

  logic [CNT_W-1:0] cnt    [N_CH];
  logic [CNT_W-1:0] shadow [N_CH];
  logic             hold;

`ifdef CLOCK_DIVIDER_BANK_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // shadow only reloads at a half-period boundary (or when idle), so a new
  // divisor can never shorten the phase already in progress.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!rst || sync) begin
        cnt[i]     <= '0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
        shadow[i]  <= div_in[i*CNT_W +: CNT_W];
        busy[i]    <= rst ? en[i] : 1'b0;
      end else if (hold) begin
        tick[i] <= 1'b0;
      end else if (!en[i]) begin
        cnt[i]     <= '0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
        busy[i]    <= 1'b0;
        shadow[i]  <= div_in[i*CNT_W +: CNT_W];
      end else begin
        busy[i] <= 1'b1;
        if (cnt[i] == shadow[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= ~clk_out[i];
          shadow[i]  <= div_in[i*CNT_W +: CNT_W];
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chk
    a_cnt_bound : assert property (@(posedge clk) rst |-> cnt[g] <= shadow[g]);
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed self-checking bench for clock_divider_bank (N_CH=2, CNT_W=8).
// Pause scenario is exercised only when CLOCK_DIVIDER_BANK_PAUSE_EN is defined.
module tb_clock_divider_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div_in;
  logic [1:0]  en;
  logic        sync;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [1:0]  busy;
`ifdef CLOCK_DIVIDER_BANK_PAUSE_EN
  logic        pause;
`endif

  int n_cmp = 0;
  int n_err = 0;

  clock_divider_bank #(.N_CH(2), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_in  (div_in),
    .en      (en),
    .sync    (sync),
`ifdef CLOCK_DIVIDER_BANK_PAUSE_EN
    .pause   (pause),
`endif
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] d, input logic [1:0] e);
    rst    = 1'b0;
    div_in = d;
    en     = e;
    sync   = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] eo, et;
    rst = 1'b0; en = 2'b11; sync = 1'b0; div_in = {8'd1, 8'd3};
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if ({clk_out, tick, busy} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_hold k=%0d got clk_out=%b tick=%b busy=%b want 00 00 00", k, clk_out, tick, busy);
      end
    end
    rst = 1'b1;
    // ch0 div 3: period 8, rise at 4,12; ch1 div 1: period 4, rise at 2,6,10,14
    for (int k = 1; k <= 16; k++) begin
      step();
      eo = {1'(((k / 2) % 2) == 1), 1'(((k / 4) % 2) == 1)};
      et = {1'((k % 4) == 2), 1'((k % 8) == 4)};
      n_cmp++;
      if ({clk_out, tick, busy} !== {eo, et, 2'b11}) begin
        n_err++;
        $display("FAIL reset_release k=%0d got %b %b %b want %b %b 11", k, clk_out, tick, busy, eo, et);
      end
    end
  endtask

  task automatic test_div_change();
    logic e0, t0;
    do_reset({8'd0, 8'd3}, 2'b01);
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) div_in[7:0] = 8'd9;
      step();
      e0 = (k >= 4 && k <= 7) || (k >= 18 && k <= 27) || (k >= 38);
      t0 = (k == 4) || (k == 18) || (k == 38);
      n_cmp++;
      if ({clk_out, tick, busy} !== {1'b0, e0, 1'b0, t0, 2'b01}) begin
        n_err++;
        $display("FAIL div_change k=%0d got %b %b %b want 0%b 0%b 01", k, clk_out, tick, busy, e0, t0);
      end
    end
  endtask

  task automatic test_boundary();
    do_reset({8'd0, 8'd0}, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if ({clk_out[0], tick[0]} !== {2{1'(k % 2)}}) begin
        n_err++;
        $display("FAIL div_zero k=%0d got out=%b tick=%b want %0d %0d", k, clk_out[0], tick[0], k % 2, k % 2);
      end
    end
    do_reset({8'd0, 8'hFF}, 2'b01);
    for (int k = 1; k <= 770; k++) begin
      step();
      if (k == 255 || k == 256 || k == 257 || k == 511 || k == 512 || k == 767 || k == 768) begin
        logic e0, t0;
        e0 = (k >= 256 && k <= 511) || k == 768;
        t0 = (k == 256) || (k == 768);
        n_cmp++;
        if ({clk_out[0], tick[0]} !== {e0, t0}) begin
          n_err++;
          $display("FAIL div_max k=%0d got out=%b tick=%b want %b %b", k, clk_out[0], tick[0], e0, t0);
        end
      end
    end
  endtask

  task automatic test_sync();
    logic e0, e1, t0, t1;
    logic [1:0] eb;
    do_reset({8'd5, 8'd3}, 2'b01);
    step(); step();
    en = 2'b11;
    step(); step(); step();
    sync = 1'b1;
    step();
    n_cmp++;
    if ({clk_out, tick, busy} !== 6'b00_00_11) begin
      n_err++;
      $display("FAIL sync_pulse got %b %b %b want 00 00 11", clk_out, tick, busy);
    end
    sync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 8) en = 2'b01;
      step();
      e0 = (k >= 4 && k <= 7) || (k >= 12);
      e1 = (k == 6) || (k == 7);
      t0 = (k == 4) || (k == 12);
      t1 = (k == 6);
      eb = (k >= 8) ? 2'b01 : 2'b11;
      n_cmp++;
      if ({clk_out, tick, busy} !== {e1, e0, t1, t0, eb}) begin
        n_err++;
        $display("FAIL sync_align k=%0d got %b %b %b want %b%b %b%b %b", k, clk_out, tick, busy, e1, e0, t1, t0, eb);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic e0, e1, t0, t1;
    do_reset({8'd1, 8'd3}, 2'b11);
    for (int k = 1; k <= 5; k++) step();
    n_cmp++;
    if (clk_out !== 2'b01) begin
      n_err++;
      $display("FAIL pre_reset_phase got clk_out=%b want 01", clk_out);
    end
    rst = 1'b0;
    div_in = {8'd1, 8'd2};
    step();
    n_cmp++;
    if ({clk_out, tick, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL mid_reset got %b %b %b want 00 00 00", clk_out, tick, busy);
    end
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      e0 = (k >= 3 && k <= 5) || (k >= 9);
      t0 = (k == 3) || (k == 9);
      e1 = ((k / 2) % 2) == 1;
      t1 = (k % 4) == 2;
      n_cmp++;
      if ({clk_out, tick, busy} !== {e1, e0, t1, t0, 2'b11}) begin
        n_err++;
        $display("FAIL post_reset k=%0d got %b %b %b want %b%b %b%b 11", k, clk_out, tick, busy, e1, e0, t1, t0);
      end
    end
  endtask

`ifdef CLOCK_DIVIDER_BANK_PAUSE_EN
  task automatic test_pause();
    logic e0, t0;
    pause = 1'b0;
    do_reset({8'd0, 8'd3}, 2'b01);
    for (int k = 1; k <= 14; k++) begin
      if (k == 6)  pause = 1'b1;
      if (k == 11) pause = 1'b0;
      step();
      e0 = (k >= 4 && k <= 12);
      t0 = (k == 4);
      n_cmp++;
      if ({clk_out, tick, busy} !== {1'b0, e0, 1'b0, t0, 2'b01}) begin
        n_err++;
        $display("FAIL pause k=%0d got %b %b %b want 0%b 0%b 01", k, clk_out, tick, busy, e0, t0);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0; en = '0; sync = 1'b0; div_in = '0;
`ifdef CLOCK_DIVIDER_BANK_PAUSE_EN
    pause = 1'b0;
`endif
    test_reset();
    test_div_change();
    test_boundary();
    test_sync();
    test_mid_reset();
`ifdef CLOCK_DIVIDER_BANK_PAUSE_EN
    test_pause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
